// File: rtl/uart_tx_serializer.sv
// Asynchronous serial transmitter: start bit, DATA_W data bits LSB first,
// optional even parity, stop bit. Words are accepted over a valid/ready handshake.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              txd,
   output logic              busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic              par;
   logic              bit_end;

   // Handshake: a word transfers on any rising edge where in_valid && in_ready.
   // in_ready depends only on state, so the producer sees it without a loop.
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign bit_end  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shift <= '0;
         cnt   <= '0;
         idx   <= '0;
         par   <= 1'b0;
         txd   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               txd <= 1'b1;
               cnt <= '0;
               if (in_valid) begin
                  shift <= in_data;
                  par   <= 1'b0;
                  idx   <= '0;
                  state <= START;
                  txd   <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= DATA;
                  txd   <= shift[0];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt   <= '0;
                  shift <= shift >> 1;
                  par   <= par ^ shift[0];
                  idx   <= idx + IDX_W'(1);
                  // txd is loaded one bit ahead so it changes exactly on the boundary
                  if (idx == IDX_W'(DATA_W - 1)) begin
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        txd   <= par ^ shift[0];
                     end else begin
                        state <= STOP;
                        txd   <= 1'b1;
                     end
                  end else begin
                     txd <= shift[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= STOP;
                  txd   <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= IDLE;
                  txd   <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations checked cycle by cycle
// against a frame model built from the framing rules.
module tb_uart_tx_serializer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance 0: C=4 W=8 P=0, instance 1: C=4 W=8 P=1, instance 2: C=2 W=5 P=0
   logic [7:0] data_a, data_b;
   logic [4:0] data_c;
   logic       valid_a, valid_b, valid_c;
   logic       ready_a, ready_b, ready_c;
   logic       txd_a, txd_b, txd_c;
   logic       busy_a, busy_b, busy_c;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0)) dut_a (
      .clk(clk), .rst(rst), .in_data(data_a), .in_valid(valid_a),
      .in_ready(ready_a), .txd(txd_a), .busy(busy_a));

   uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1)) dut_b (
      .clk(clk), .rst(rst), .in_data(data_b), .in_valid(valid_b),
      .in_ready(ready_b), .txd(txd_b), .busy(busy_b));

   uart_tx_serializer #(.CLKS_PER_BIT(2), .DATA_W(5), .PARITY_EN(0)) dut_c (
      .clk(clk), .rst(rst), .in_data(data_c), .in_valid(valid_c),
      .in_ready(ready_c), .txd(txd_c), .busy(busy_c));

   function automatic int cfg_c(input int sel);
      return (sel == 2) ? 2 : 4;
   endfunction
   function automatic int cfg_w(input int sel);
      return (sel == 2) ? 5 : 8;
   endfunction
   function automatic int cfg_p(input int sel);
      return (sel == 1) ? 1 : 0;
   endfunction

   function automatic logic obs_txd(input int sel);
      return (sel == 0) ? txd_a : (sel == 1) ? txd_b : txd_c;
   endfunction
   function automatic logic obs_busy(input int sel);
      return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
   endfunction
   function automatic logic obs_ready(input int sel);
      return (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;
   endfunction

   task automatic drive(input int sel, input logic [15:0] d, input logic v);
      case (sel)
         0: begin data_a = d[7:0]; valid_a = v; end
         1: begin data_b = d[7:0]; valid_b = v; end
         default: begin data_c = d[4:0]; valid_c = v; end
      endcase
   endtask

   // Expected line level for each cycle after the accept edge.
   task automatic build_frame(input int sel, input logic [15:0] word, output logic q[$]);
      int  c, w;
      logic p_acc;
      c = cfg_c(sel);
      w = cfg_w(sel);
      p_acc = 1'b0;
      q = {};
      for (int j = 0; j < c; j++) q.push_back(1'b0);
      for (int i = 0; i < w; i++) begin
         p_acc = p_acc ^ word[i];
         for (int j = 0; j < c; j++) q.push_back(word[i]);
      end
      if (cfg_p(sel) != 0)
         for (int j = 0; j < c; j++) q.push_back(p_acc);
      for (int j = 0; j < c; j++) q.push_back(1'b1);
   endtask

   // Called at a negedge; returns at the negedge of the first idle cycle after the frame.
   task automatic run_frame(input int sel, input logic [15:0] word, input bit hold);
      logic q[$];
      int   k;
      k = 0;
      while (obs_ready(sel) !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (obs_ready(sel) !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_wait dut%0d: in_ready=%b required 1 within 200 cycles", sel, obs_ready(sel));
      end
      build_frame(sel, word, q);
      drive(sel, word, 1'b1);
      @(posedge clk);
      #1;
      drive(sel, 16'($urandom), hold);
      for (int t = 0; t < q.size(); t++) begin
         @(negedge clk);
         n_checks++;
         if (obs_txd(sel) !== q[t]) begin
            n_fail++;
            $display("FAIL frame_txd dut%0d word=%h cycle N+%0d: txd=%b required %b", sel, word, t + 1, obs_txd(sel), q[t]);
         end
         n_checks++;
         if (obs_busy(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_busy dut%0d cycle N+%0d: busy=%b required 1", sel, t + 1, obs_busy(sel));
         end
         n_checks++;
         if (obs_ready(sel) !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_ready dut%0d cycle N+%0d: in_ready=%b required 0", sel, t + 1, obs_ready(sel));
         end
         if (hold) drive(sel, 16'($urandom), 1'b1);
      end
      @(negedge clk);
      n_checks++;
      if (obs_busy(sel) !== 1'b0 || obs_ready(sel) !== 1'b1 || obs_txd(sel) !== 1'b1) begin
         n_fail++;
         $display("FAIL end_idle dut%0d cycle N+%0d: busy=%b in_ready=%b txd=%b required 0 1 1",
                  sel, q.size() + 1, obs_busy(sel), obs_ready(sel), obs_txd(sel));
      end
   endtask

   task automatic check_idle(input int sel, input string name);
      n_checks++;
      if (obs_txd(sel) !== 1'b1 || obs_busy(sel) !== 1'b0 || obs_ready(sel) !== 1'b1) begin
         n_fail++;
         $display("FAIL %s dut%0d: txd=%b busy=%b in_ready=%b required 1 0 1",
                  name, sel, obs_txd(sel), obs_busy(sel), obs_ready(sel));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 16'h00A5, 1'b1);
      drive(1, 16'h0000, 1'b0);
      drive(2, 16'h0000, 1'b0);
      repeat (3) begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) check_idle(s, "reset_state");
      end
      rst = 1'b0;
      drive(0, 16'h0000, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check_idle(0, "accept_in_reset_discarded");
      end
   endtask

   task automatic test_reset_mid_frame();
      drive(0, 16'h0033, 1'b1);
      @(posedge clk);
      #1;
      drive(0, 16'h0000, 1'b0);
      repeat (18) @(negedge clk);
      n_checks++;
      if (busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_frame_busy: busy=%b required 1", busy_a);
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_idle(0, "reset_mid_frame");
      end
      rst = 1'b0;
      repeat (50) begin
         @(negedge clk);
         check_idle(0, "after_reset_no_bits");
      end
   endtask

   task automatic test_single_frame();
      run_frame(0, 16'h00A5, 1'b0);
   endtask

   task automatic test_parity();
      run_frame(1, 16'h00A5, 1'b0);
      run_frame(1, 16'h0007, 1'b0);
   endtask

   task automatic test_back_to_back();
      // valid held with data churning mid-frame; each call accepts at the first idle edge
      run_frame(0, 16'h003C, 1'b1);
      run_frame(0, 16'h00C3, 1'b1);
      run_frame(0, 16'h0081, 1'b0);
   endtask

   task automatic test_boundary();
      run_frame(2, 16'h001F, 1'b0);
      run_frame(2, 16'h0000, 1'b0);
   endtask

   task automatic test_random();
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < 4; i++)
            run_frame(s, 16'($urandom_range(0, 65535)), i[0]);
   endtask

   initial begin
      rst = 1'b1;
      data_a = '0; data_b = '0; data_c = '0;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_parity();
      test_back_to_back();
      test_boundary();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-serial transmitter for the processor's debug/host link: accepts a parallel data word over a valid/ready handshake and shifts it out on a single line as an asynchronous serial frame. Framing is start bit, data bits LSB first, optional even parity, then stop bit. It is the sending end of the link whose receive side captures incoming bits into enable-gated flops. It sits between the memory-mapped debug port and the board TX pin.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range ≥ 2.
- DATA_W, default 8: data bits per frame; legal range 5–16.
- PARITY_EN, default 0: when 1, an even-parity bit is inserted after the data bits.
- clk  in  1  system clock; single clock domain, all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_data  in  DATA_W  word to transmit; sampled only on the accept cycle.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  block can accept a word this cycle.
- txd  out  1  serial line; idles high.
- busy  out  1  a frame is in progress, i.e. state is not IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Internal registers:
  - shift register (DATA_W bits);
  - bit-period counter (clog2(CLKS_PER_BIT) bits);
  - bit index counter (clog2(DATA_W+1) bits);
  - parity accumulator (1 bit).
- Accept: occurs when in_valid && in_ready.
  - in_data is loaded into the shift register.
  - Parity accumulator clears.
  - State goes IDLE -> START.
- in_ready is 1 only in IDLE and is combinational from state. in_valid while not ready is ignored; no data is captured.
- START: txd = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - txd = shift[0].
  - At the end of each bit period: shift right by 1, XOR the sent bit into parity, increment bit index.
  - After DATA_W bits: go to PARITY if PARITY_EN, else go to STOP.
- PARITY: txd = accumulated XOR of the data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: txd = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Bit-period counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Resets to 0 on every state transition.
  - Wraps to 0 at the end of each bit.
- txd is a registered output; it has no combinational path from in_data.
- Changes to in_data or in_valid after the accept cycle have no effect on the frame in flight.

## Timing
- Reset values: state = IDLE, txd = 1, busy = 0, in_ready = 1 (combinational from IDLE), all counters = 0, shift register = 0.
- Reset mid-frame: on the next edge txd = 1 and state = IDLE. The partial frame is abandoned and the word is discarded.
- Reset dominates: an accept presented in the reset cycle is discarded.
- Accept at edge N:
  - Cycle N+1: txd = 0 (start bit) and busy = 1.
  - Data bit k occupies cycles N+1+(k+1)·CLKS_PER_BIT through N+(k+2)·CLKS_PER_BIT.
- Frame length F = (DATA_W + 2 + PARITY_EN)·CLKS_PER_BIT cycles of driven start..stop.
- Return to idle: state is IDLE and in_ready = 1 at cycle N+1+F. The earliest next accept is at edge N+1+F.
- Back-to-back throughput: one word every F+1 cycles. The idle-high gap between frames is exactly 1 cycle beyond the stop bit.
- txd changes only on bit-period boundaries; it never glitches mid-bit.

## Test plan
- Reset/idle:
  - Stimulus: assert rst for 3 cycles mid-DATA of a frame.
  - Required: txd = 1, busy = 0, in_ready = 1 on the edge after rst rises; they stay so while rst is held.
  - Required: no further frame bits after rst deasserts.
- Single frame:
  - Setup: CLKS_PER_BIT = 4, DATA_W = 8, PARITY_EN = 0; send 0xA5.
  - Required txd, in 4-cycle bits: 0, 1, 0, 1, 0, 0, 1, 0, 1, 1.
  - Required: busy high for 40 cycles; in_ready back at cycle N+41.
- Parity:
  - Setup: PARITY_EN = 1.
  - Send 0xA5: required parity bit = 0, frame = 44 cycles.
  - Send 0x07: required parity bit = 1.
- Handshake:
  - Stimulus: hold in_valid = 1 with changing in_data during a frame.
  - Required: only the word present at the accept edge is sent.
  - Required: the next word is accepted exactly at cycle N+41; throughput is one frame per 41 cycles.
- Boundary:
  - Setup: CLKS_PER_BIT = 2, DATA_W = 5; send 0x1F and 0x00.
  - Required: every bit is exactly 2 cycles.
  - Required frames: 0, 1, 1, 1, 1, 1, 1 for 0x1F and 0, 0, 0, 0, 0, 0, 1 for 0x00.
  - Required: the bit-period counter wraps correctly.
